ps2_scan_tracker: RTL and testbench

- Receives the raw PS/2 keyboard clock/data pair, deserialises 11-bit frames and decodes make / auto-repeat / break (F0) sequences.
- Tracks the currently held key and counts presses.
- Its `code` and `seg_en` outputs feed the two-digit hex seven-segment decoder directly: `code` drives the byte input, `seg_en` drives the blank-when-low enable.
- `press_cnt` feeds a second decoder instance.

---
 rtl/ps2_scan_tracker_if.sv | 21 ++
 rtl/ps2_scan_tracker.sv | 148 ++++++++++++++
 tb/tb_ps2_scan_tracker.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_tracker_if.sv
// PS/2 scan tracker port bundle: raw keyboard lines in,
// decoded key state and frame pulses out.
interface ps2_scan_tracker_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       seg_en;
    logic [7:0] press_cnt;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  code, seg_en, press_cnt, frame_done, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output code, seg_en, press_cnt, frame_done, frame_err
    );
endinterface

// File: rtl/ps2_scan_tracker.sv
// PS/2 keyboard frame receiver with make/repeat/break key tracking.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scan_tracker #(
    parameter int TIMEOUT_CYC = 50000
) (
    input logic clk,
    input logic clrn,
    ps2_scan_tracker_if.slave bus
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_BREAK
    } state_t;

    logic [2:0]    ps2c_q, ps2c_d;
    logic [1:0]    ps2d_q, ps2d_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    buf_q, buf_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    state_t        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic          seg_q, seg_d;
    logic [7:0]    cnt_q, cnt_d;

    logic       fall;
    logic       timeout;
    logic       par_ok;
    logic       frame_ok;
    logic [7:0] rx_byte;

    always_comb begin
        ps2c_d   = {ps2c_q[1:0], bus.ps2_clk};
        ps2d_d   = {ps2d_q[0], bus.ps2_data};
        bitcnt_d = bitcnt_q;
        buf_d    = buf_q;
        idle_d   = idle_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fall     = ps2c_q[2] & ~ps2c_q[1];
        timeout  = (bitcnt_q != 4'd0) &&
                   (idle_q == IW'(TIMEOUT_CYC - 1));
`ifdef PS2_PARITY_CHECK_EN
        par_ok   = ^buf_q[9:1];
`else
        par_ok   = 1'b1;
`endif
        // buf_q still holds start..parity before the stop bit lands
        frame_ok = ~buf_q[0] & ps2d_q[1] & par_ok;
        if (fall) begin
            buf_d  = {ps2d_q[1], buf_q[9:1]};
            idle_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = 4'd0;
                done_d   = frame_ok;
                err_d    = ~frame_ok;
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (timeout) begin
            bitcnt_d = 4'd0;
            buf_d    = '0;
            idle_d   = '0;
        end else if (bitcnt_q != 4'd0) begin
            idle_d = idle_q + IW'(1);
        end
    end

    assign rx_byte = buf_q[7:0];

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        if (done_q && rx_byte != 8'hE0) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_byte == 8'hF0) begin
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_PRESSED;
                        code_d  = rx_byte;
                        seg_d   = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                S_PRESSED: begin
                    if (rx_byte == code_q) begin
                        state_d = S_PRESSED;
                    end else if (rx_byte == 8'hF0) begin
                        state_d = S_BREAK;
                    end else begin
                        code_d = rx_byte;
                        cnt_d  = cnt_q + 8'd1;
                    end
                end
                S_BREAK: begin
                    if (seg_q && rx_byte != code_q) begin
                        state_d = S_PRESSED;
                    end else begin
                        state_d = S_IDLE;
                        seg_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2c_q   <= 3'b111;
            ps2d_q   <= 2'b11;
            bitcnt_q <= 4'd0;
            buf_q    <= '0;
            idle_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= S_IDLE;
            code_q   <= 8'h00;
            seg_q    <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            ps2c_q   <= ps2c_d;
            ps2d_q   <= ps2d_d;
            bitcnt_q <= bitcnt_d;
            buf_q    <= buf_d;
            idle_q   <= idle_d;
            done_q   <= done_d;
            err_q    <= err_d;
            state_q  <= state_d;
            code_q   <= code_d;
            seg_q    <= seg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.seg_en     = seg_q;
    assign bus.press_cnt  = cnt_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_ps2_scan_tracker.sv
// Directed plus random frame bench for ps2_scan_tracker
// against a key-state reference model.
module tb_ps2_scan_tracker;
    localparam int TO   = 200;
    localparam int HALF = 4;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clrn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   nd = 0;
    int   ne = 0;

    logic [7:0] m_code;
    logic       m_seg;
    logic [7:0] m_cnt;
    logic       m_brk;

    ps2_scan_tracker_if bus ();

    ps2_scan_tracker #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_done) nd++;
        if (bus.frame_err) ne++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_code = 8'h00;
        m_seg  = 1'b0;
        m_cnt  = 8'h00;
        m_brk  = 1'b0;
    endtask

    // Key-state view: a pending release flag plus the held key.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) return;
        if (m_brk) begin
            m_brk = 1'b0;
            if (!(m_seg && b != m_code)) m_seg = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
        if (m_seg && b == m_code) return;
        m_code = b;
        m_seg  = 1'b1;
        m_cnt  = m_cnt + 8'd1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_code"}, {24'd0, bus.code}, {24'd0, m_code});
        check({tag, "_seg"}, {31'd0, bus.seg_en}, {31'd0, m_seg});
        check({tag, "_cnt"}, {24'd0, bus.press_cnt}, {24'd0, m_cnt});
    endtask

    // fault: 0 none, 1 parity flipped, 2 start high, 3 stop low
    task automatic send_frame(input logic [7:0] b, input int fault);
        logic [10:0] f;
        logic        ok;
        logic        found;
        int          k;
        int          nd0;
        int          ne0;
        f = {1'b1, ~^b, b, 1'b0};
        if (fault == 1) f[9] = ~f[9];
        if (fault == 2) f[0] = 1'b1;
        if (fault == 3) f[10] = 1'b0;
        ok  = (fault == 0) || (fault == 1 && !PAR_EN);
        nd0 = nd;
        ne0 = ne;
        for (int i = 0; i < 11; i++) begin
            bus.ps2_data = f[i];
            bus.ps2_clk  = 1'b1;
            wait_cyc(HALF);
            bus.ps2_clk = 1'b0;
            if (i < 10) wait_cyc(HALF);
        end
        found = 1'b0;
        k = 0;
        while (!found && k < 12) begin
            @(negedge clk);
            k++;
            if (bus.frame_done || bus.frame_err) found = 1'b1;
        end
        check("frame_seen", {31'd0, found}, 32'd1);
        if (found) begin
            check("done_lvl", {31'd0, bus.frame_done}, {31'd0, ok});
            check("err_lvl", {31'd0, bus.frame_err}, {31'd0, ~ok});
            check_outs("pre");
            if (ok) model_byte(b);
            @(negedge clk);
            check("done_low", {31'd0, bus.frame_done}, 32'd0);
            check("err_low", {31'd0, bus.frame_err}, 32'd0);
            check_outs("post");
        end
        bus.ps2_clk = 1'b1;
        wait_cyc(HALF);
        check("done_pulses", nd - nd0, {31'd0, ok});
        check("err_pulses", ne - ne0, {31'd0, ~ok});
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = 1'($urandom_range(0, 1));
            bus.ps2_clk  = 1'b1;
            wait_cyc(HALF);
            bus.ps2_clk = 1'b0;
            wait_cyc(HALF);
        end
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        wait_cyc(3);
        clrn = 1'b1;
        model_reset();
        wait_cyc(3);
    endtask

    initial begin
        int nd0;
        int ne0;
        logic [7:0] b;
        int r;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        wait_cyc(3);
        check_outs("reset");
        check("reset_done", {31'd0, bus.frame_done}, 32'd0);
        check("reset_err", {31'd0, bus.frame_err}, 32'd0);
        clrn = 1'b1;
        wait_cyc(3);

        send_frame(8'h1C, 0);
        check("first_cnt", {24'd0, bus.press_cnt}, 32'd1);
        repeat (3) send_frame(8'h1C, 0);
        check("repeat_cnt", {24'd0, bus.press_cnt}, 32'd1);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check("break_seg", {31'd0, bus.seg_en}, 32'd0);
        check("break_code", {24'd0, bus.code}, 32'h1C);
        send_frame(8'h32, 0);
        check("second_cnt", {24'd0, bus.press_cnt}, 32'd2);
        send_frame(8'h1C, 1);
        send_frame(8'h45, 2);
        send_frame(8'h46, 3);

        nd0 = nd;
        ne0 = ne;
        send_partial(5);
        wait_cyc(TO + 10);
        check("to_done", nd - nd0, 32'd0);
        check("to_err", ne - ne0, 32'd0);
        send_frame(8'h24, 0);
        check("to_code", {24'd0, bus.code}, 32'h24);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0: b = 8'h1C;
                1: b = 8'h32;
                2: b = 8'hF0;
                3: b = 8'hE0;
                default: b = 8'($urandom);
            endcase
            send_frame(b, ($urandom_range(0, 5) == 0) ?
                       int'($urandom_range(1, 3)) : 0);
        end

        do_reset();
        for (int i = 0; i < 256; i++)
            send_frame((i % 2 == 0) ? 8'h1C : 8'h32, 0);
        check("wrap_cnt", {24'd0, bus.press_cnt}, 32'd0);
        send_frame(8'h24, 0);

        send_partial(5);
        bus.ps2_clk = 1'b0;
        wait_cyc(1);
        clrn = 1'b0;
        #1;
        model_reset();
        check_outs("abort");
        check("abort_done", {31'd0, bus.frame_done}, 32'd0);
        check("abort_err", {31'd0, bus.frame_err}, 32'd0);
        bus.ps2_clk = 1'b1;
        wait_cyc(3);
        clrn = 1'b1;
        wait_cyc(3);
        send_frame(8'h1C, 0);
        check("after_abort", {24'd0, bus.code}, 32'h1C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
